// File: rtl/spi_sts_sync_pkg.sv
// Shared constants for the SPI-to-AXI status synchronizer.
package spi_sts_sync_pkg;

    localparam int FAULT_CODE_W = 4;
    localparam logic [FAULT_CODE_W-1:0] FAULT_NONE = 4'd0;

endpackage

// File: rtl/spi_sts_sync_field.sv
// One status field: multi-flop synchronizer followed by a stability qualifier.
module sts_field_sync #(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             stable
);

    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync_q [DEPTH];
    logic [WIDTH-1:0] dout_d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign dout = sync_q[DEPTH-1];
    // A change still sitting between dout and dout_d must block stability.
    assign stable = (cnt_q == CNT_MAX) && (dout == dout_d_q);

    // Synchronizer chain and one-cycle delayed copy of its output.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
            dout_d_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dout_d_q <= dout;
        end
    end

    // Saturating count of consecutive unchanged cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (dout != dout_d_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stability counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sts_sync.sv
// SPI-domain status returned to aclk: per-field sync, coherent commit,
// sticky over-threshold flags and first-fault latch.
module spi_sts_sync
    import spi_sts_sync_pkg::*;
#(
    parameter int N_CH         = 8,
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    spi_running,
    input  logic                    spi_done,
    input  logic [N_CH-1:0]         over_thresh,
    input  logic [FAULT_CODE_W-1:0] fault_code,
    input  logic                    clr_sticky,
    input  logic                    clr_fault,
    output logic                    spi_running_sts,
    output logic                    spi_done_sts,
    output logic [N_CH-1:0]         over_thresh_sts,
    output logic [FAULT_CODE_W-1:0] fault_code_sts,
    output logic [N_CH-1:0]         over_thresh_sticky,
    output logic [FAULT_CODE_W-1:0] fault_latched,
    output logic                    fault_irq,
    output logic                    sts_changed
);

    logic                    run_sync, done_sync;
    logic [N_CH-1:0]         ot_sync;
    logic [FAULT_CODE_W-1:0] fc_sync;
    logic                    run_stable, done_stable, ot_stable, fc_stable;
    logic                    all_stable;

    logic                    run_q, run_d, done_q, done_d;
    logic [N_CH-1:0]         ot_q, ot_d, sticky_q, sticky_d;
    logic [FAULT_CODE_W-1:0] fc_q, fc_d, fault_q, fault_d;
    logic                    changed_q, changed_d;

    sts_field_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_run_sync (
        .aclk(aclk), .aresetn(aresetn), .din(spi_running), .dout(run_sync), .stable(run_stable)
    );
    sts_field_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_done_sync (
        .aclk(aclk), .aresetn(aresetn), .din(spi_done), .dout(done_sync), .stable(done_stable)
    );
    sts_field_sync #(.WIDTH(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_ot_sync (
        .aclk(aclk), .aresetn(aresetn), .din(over_thresh), .dout(ot_sync), .stable(ot_stable)
    );
    sts_field_sync #(.WIDTH(FAULT_CODE_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_fc_sync (
        .aclk(aclk), .aresetn(aresetn), .din(fault_code), .dout(fc_sync), .stable(fc_stable)
    );

    assign all_stable = run_stable & done_stable & ot_stable & fc_stable;

    // Commit all fields together, then derive sticky and fault state from the committed values.
    always_comb begin
        run_d     = run_q;
        done_d    = done_q;
        ot_d      = ot_q;
        fc_d      = fc_q;
        changed_d = 1'b0;
        if (all_stable) begin
            run_d     = run_sync;
            done_d    = done_sync;
            ot_d      = ot_sync;
            fc_d      = fc_sync;
            changed_d = ({run_sync, done_sync, ot_sync, fc_sync} != {run_q, done_q, ot_q, fc_q});
        end else begin
            changed_d = 1'b0;
        end

        sticky_d = (clr_sticky ? '0 : sticky_q) | ot_d;

        if (clr_fault) begin
            fault_d = fc_d;
        end else if ((fault_q == FAULT_NONE) && (fc_d != FAULT_NONE)) begin
            fault_d = fc_d;
        end else begin
            fault_d = fault_q;
        end
    end

    // Committed status, sticky and fault registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            ot_q      <= '0;
            fc_q      <= FAULT_NONE;
            sticky_q  <= '0;
            fault_q   <= FAULT_NONE;
            changed_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            done_q    <= done_d;
            ot_q      <= ot_d;
            fc_q      <= fc_d;
            sticky_q  <= sticky_d;
            fault_q   <= fault_d;
            changed_q <= changed_d;
        end
    end

    assign spi_running_sts    = run_q;
    assign spi_done_sts       = done_q;
    assign over_thresh_sts    = ot_q;
    assign fault_code_sts     = fc_q;
    assign over_thresh_sticky = sticky_q;
    assign fault_latched      = fault_q;
    assign fault_irq          = (fault_q != FAULT_NONE);
    assign sts_changed        = changed_q;

endmodule

// File: tb/tb_spi_sts_sync.sv
// Self-checking bench for spi_sts_sync: sliding-window reference model plus directed literal checks.
module tb_spi_sts_sync;

    localparam int N_CH = 8;
    localparam int D    = 3;
    localparam int SC   = 2;
    localparam int HL   = D + SC + 1;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b1;
    logic       spi_running = 1'b0, spi_done = 1'b0;
    logic [7:0] over_thresh = 8'h00;
    logic [3:0] fault_code = 4'h0;
    logic       clr_sticky = 1'b0, clr_fault = 1'b0;
    logic       spi_running_sts, spi_done_sts, fault_irq, sts_changed;
    logic [7:0] over_thresh_sts, over_thresh_sticky;
    logic [3:0] fault_code_sts, fault_latched;

    int total = 0;
    int bad = 0;

    spi_sts_sync #(.N_CH(N_CH), .DEPTH(D), .STABLE_COUNT(SC)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .spi_running(spi_running), .spi_done(spi_done),
        .over_thresh(over_thresh), .fault_code(fault_code),
        .clr_sticky(clr_sticky), .clr_fault(clr_fault),
        .spi_running_sts(spi_running_sts), .spi_done_sts(spi_done_sts),
        .over_thresh_sts(over_thresh_sts), .fault_code_sts(fault_code_sts),
        .over_thresh_sticky(over_thresh_sticky), .fault_latched(fault_latched),
        .fault_irq(fault_irq), .sts_changed(sts_changed)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a field is stable on edge k when the samples taken on edges
    // k-D-SC-1 .. k-D are all equal (pre-reset samples read as 0) and at least SC
    // edges have elapsed since reset release; the committed value is sample k-D.
    logic       h_run [HL];
    logic       h_done [HL];
    logic [7:0] h_ot [HL];
    logic [3:0] h_fc [HL];
    int         m_k;
    logic       m_run, m_done, m_chg;
    logic [7:0] m_ot, m_sticky;
    logic [3:0] m_fc, m_fault;

    always begin
        logic st;
        @(posedge aclk);
        if (!aresetn) begin
            for (int i = 0; i < HL; i++) begin
                h_run[i] = 1'b0; h_done[i] = 1'b0; h_ot[i] = 8'h00; h_fc[i] = 4'h0;
            end
            m_k = 0;
            m_run = 1'b0; m_done = 1'b0; m_ot = 8'h00; m_fc = 4'h0;
            m_sticky = 8'h00; m_fault = 4'h0; m_chg = 1'b0;
        end else begin
            st = (m_k >= SC);
            for (int i = D - 1; i < D + SC; i++) begin
                if (h_run[i] != h_run[i+1] || h_done[i] != h_done[i+1] ||
                    h_ot[i] != h_ot[i+1] || h_fc[i] != h_fc[i+1]) st = 1'b0;
            end
            if (st) begin
                m_chg  = ({h_run[D-1], h_done[D-1], h_ot[D-1], h_fc[D-1]} != {m_run, m_done, m_ot, m_fc});
                m_run  = h_run[D-1];
                m_done = h_done[D-1];
                m_ot   = h_ot[D-1];
                m_fc   = h_fc[D-1];
            end else begin
                m_chg = 1'b0;
            end
            m_sticky = (clr_sticky ? 8'h00 : m_sticky) | m_ot;
            if (clr_fault) m_fault = m_fc;
            else if (m_fault == 4'h0 && m_fc != 4'h0) m_fault = m_fc;
            for (int i = HL - 1; i > 0; i--) begin
                h_run[i] = h_run[i-1]; h_done[i] = h_done[i-1];
                h_ot[i] = h_ot[i-1]; h_fc[i] = h_fc[i-1];
            end
            h_run[0] = spi_running; h_done[0] = spi_done;
            h_ot[0] = over_thresh; h_fc[0] = fault_code;
            m_k++;
        end
        #1;
        chk("model_running_sts", spi_running_sts, m_run);
        chk("model_done_sts", spi_done_sts, m_done);
        chk("model_ot_sts", over_thresh_sts, m_ot);
        chk("model_fc_sts", fault_code_sts, m_fc);
        chk("model_sticky", over_thresh_sticky, m_sticky);
        chk("model_fault_latched", fault_latched, m_fault);
        chk("model_fault_irq", fault_irq, (m_fault != 4'h0));
        chk("model_sts_changed", sts_changed, m_chg);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    initial begin
        int pulses;
        // 1: reset with arbitrary inputs, then latency of a held spi_running
        #1 aresetn = 1'b0;
        spi_running = 1'b1; spi_done = 1'b1; over_thresh = 8'hA5; fault_code = 4'h9;
        cyc(3);
        chk("rst_running_sts", spi_running_sts, 1'b0);
        chk("rst_done_sts", spi_done_sts, 1'b0);
        chk("rst_ot_sts", over_thresh_sts, 8'h00);
        chk("rst_fc_sts", fault_code_sts, 4'h0);
        chk("rst_sticky", over_thresh_sticky, 8'h00);
        chk("rst_fault_latched", fault_latched, 4'h0);
        chk("rst_fault_irq", fault_irq, 1'b0);
        chk("rst_sts_changed", sts_changed, 1'b0);
        spi_running = 1'b1; spi_done = 1'b0; over_thresh = 8'h00; fault_code = 4'h0;
        aresetn = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            cyc(1);
            if (e == 5) chk("lat_running_e5", spi_running_sts, 1'b0);
            if (e == 6) begin
                chk("lat_running_e6", spi_running_sts, 1'b1);
                chk("lat_changed_e6", sts_changed, 1'b1);
            end
            if (e == 7) chk("lat_changed_e7", sts_changed, 1'b0);
        end

        // 2: fast-toggling fault code never commits
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            fault_code = ((c / 2) % 2 == 0) ? 4'h3 : 4'h0;
            cyc(1);
            if (sts_changed) pulses++;
        end
        fault_code = 4'h0;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            if (sts_changed) pulses++;
        end
        chk("toggle_no_change", pulses, 0);
        chk("toggle_fc_sts", fault_code_sts, 4'h0);
        chk("toggle_fault_latched", fault_latched, 4'h0);
        chk("toggle_running_sts", spi_running_sts, 1'b1);

        // 3: sticky over-threshold and clear coincident with a set
        over_thresh = 8'h05; cyc(10);
        over_thresh = 8'h00; cyc(10);
        chk("ot_back_to_zero", over_thresh_sts, 8'h00);
        chk("ot_sticky_kept", over_thresh_sticky, 8'h05);
        over_thresh = 8'h80; cyc(6);
        clr_sticky = 1'b1; cyc(1);
        clr_sticky = 1'b0;
        chk("ot_clr_on_commit_sts", over_thresh_sts, 8'h80);
        chk("ot_clr_on_commit_sticky", over_thresh_sticky, 8'h80);

        // 4: first-fault latch and clear behaviour
        fault_code = 4'h2; cyc(10);
        fault_code = 4'h7; cyc(10);
        chk("fault_first", fault_latched, 4'h2);
        chk("fault_irq_set", fault_irq, 1'b1);
        clr_fault = 1'b1; cyc(1); clr_fault = 1'b0;
        chk("fault_relatch", fault_latched, 4'h7);
        fault_code = 4'h0; cyc(10);
        clr_fault = 1'b1; cyc(1); clr_fault = 1'b0;
        chk("fault_cleared", fault_latched, 4'h0);
        chk("fault_irq_clr", fault_irq, 1'b0);

        // 5: two fields changing on the same edge commit with one pulse
        pulses = 0;
        over_thresh = 8'h3C; spi_done = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc(1);
            if (sts_changed) pulses++;
        end
        chk("joint_one_pulse", pulses, 1);
        chk("joint_done_sts", spi_done_sts, 1'b1);
        chk("joint_ot_sts", over_thresh_sts, 8'h3C);

        // 6: reset during settling restarts the full latency
        spi_done = 1'b0; cyc(10);
        spi_done = 1'b1; cyc(3);
        aresetn = 1'b0; #1;
        chk("midrst_done_sts", spi_done_sts, 1'b0);
        cyc(2);
        aresetn = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            cyc(1);
            if (e == 5) chk("midrst_done_e5", spi_done_sts, 1'b0);
            if (e == 6) chk("midrst_done_e6", spi_done_sts, 1'b1);
        end

        // Randomized phase checked by the model every cycle
        for (int it = 0; it < 1200; it++) begin
            int hold;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: spi_running = $urandom_range(0, 1);
                    1: spi_done = $urandom_range(0, 1);
                    2: over_thresh = 8'($urandom_range(0, 255));
                    default: fault_code = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                endcase
            end
            if ($urandom_range(0, 199) == 0) begin
                aresetn = 1'b0; cyc(2); aresetn = 1'b1;
            end
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) begin
                clr_sticky = ($urandom_range(0, 7) == 0);
                clr_fault = ($urandom_range(0, 9) == 0);
                cyc(1);
            end
            clr_sticky = 1'b0; clr_fault = 1'b0;
        end
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
